// File: rtl/vram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vram_port_arbiter
//  Description : Single-port frame VRAM owner. VGA scan-out always wins the
//                port while it is reading; two pixel writers (clear engine,
//                sprite drawer) share the remaining cycles round-robin.
//                Also produces vblank and a completed-frame counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_port_arbiter #(
  parameter int FB_W = 320,
  parameter int FB_H = 240,
  parameter int AW   = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  // VGA timing side
  input  logic [9:0]    vga_row_i,
  input  logic [9:0]    vga_col_i,
  input  logic          vga_rdn_i,
  output logic [11:0]   vga_din_o,
  // VRAM port
  output logic [AW-1:0] ram_addr_o,
  output logic          ram_we_o,
  output logic [11:0]   ram_wdata_o,
  input  logic [11:0]   ram_rdata_i,
  // Writer 0 (background clear engine)
  input  logic          req0_valid_i,
  input  logic [AW-1:0] req0_addr_i,
  input  logic [11:0]   req0_data_i,
  output logic          req0_ready_o,
  // Writer 1 (sprite drawer)
  input  logic          req1_valid_i,
  input  logic [AW-1:0] req1_addr_i,
  input  logic [11:0]   req1_data_i,
  output logic          req1_ready_o,
  // Frame sync
  output logic          vblank_o,
  output logic [15:0]   frame_cnt_o,
  output logic          addr_err_o
);

  // One extra bit so the bound still fits when FB_W*FB_H == 2**AW.
  localparam int unsigned    c_PIX_W      = AW + 1;
  localparam logic [AW:0]    c_FB_PIXELS  = c_PIX_W'(FB_W * FB_H);
  localparam logic [9:0]     c_VBLANK_ROW = 10'd480;

  // Registered state
  logic          rr_ptr_q,     rr_ptr_d;
  logic          rd_pend_q,    rd_pend_d;
  logic          vblank_q,     vblank_d;
  logic [15:0]   frame_cnt_q,  frame_cnt_d;
  logic          addr_err_q,   addr_err_d;
  logic [AW-1:0] addr_hold_q,  addr_hold_d;
  logic [11:0]   wdata_hold_q, wdata_hold_d;

  // Combinational decode
  logic          w_scan;
  logic          w_any_valid;
  logic          w_both_valid;
  logic          w_write;
  logic          w_grant;
  logic [AW-1:0] w_sel_addr;
  logic [11:0]   w_sel_data;
  logic          w_oob;
  logic [AW-1:0] w_row_half;
  logic [AW-1:0] w_col_half;
  logic [AW-1:0] w_scan_addr;
  logic          w_unused_col_lsb;

  // Each framebuffer pixel covers a 2x2 screen block, so column LSB is ignored.
  assign w_unused_col_lsb = vga_col_i[0];

  assign w_row_half = AW'(vga_row_i[9:1]);
  assign w_col_half = AW'(vga_col_i[9:1]);

  // Linear scan address row*FB_W + col; the default width uses two shifts.
  generate
    if (FB_W == 320) begin : g_mul_shift
      assign w_scan_addr = (w_row_half << 8) + (w_row_half << 6) + w_col_half;
    end else begin : g_mul_generic
      assign w_scan_addr = (w_row_half * AW'(FB_W)) + w_col_half;
    end
  endgenerate

  // Mode and grant decode: scan beats writers, writers contend round-robin.
  always_comb begin
    w_scan       = ~vga_rdn_i;
    w_any_valid  = req0_valid_i | req1_valid_i;
    w_both_valid = req0_valid_i & req1_valid_i;
    w_write      = vga_rdn_i & w_any_valid;
    // A lone requester wins outright; contention is settled by rr_ptr.
    w_grant      = w_both_valid ? rr_ptr_q : req1_valid_i;
    w_sel_addr   = w_grant ? req1_addr_i : req0_addr_i;
    w_sel_data   = w_grant ? req1_data_i : req0_data_i;
    w_oob        = ({1'b0, w_sel_addr} >= c_FB_PIXELS);
  end

  // Port drive; gated by rst_n so no write or grant can leak out during reset.
  always_comb begin
    ram_addr_o   = '0;
    ram_we_o     = 1'b0;
    ram_wdata_o  = '0;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    if (rst_n) begin
      ram_addr_o  = addr_hold_q;
      ram_wdata_o = wdata_hold_q;
      if (w_scan) begin
        ram_addr_o = w_scan_addr;
      end else if (w_write) begin
        ram_addr_o   = w_sel_addr;
        ram_wdata_o  = w_sel_data;
        // Out-of-range pixels are still accepted so the writer never stalls.
        ram_we_o     = ~w_oob;
        req0_ready_o = ~w_grant;
        req1_ready_o = w_grant;
      end
    end
  end

  // Next-state logic for arbitration, read tracking and frame sync.
  always_comb begin
    addr_hold_d  = ram_addr_o;
    wdata_hold_d = ram_wdata_o;
    rr_ptr_d     = rr_ptr_q;
    if (w_write && w_both_valid) begin
      rr_ptr_d = ~w_grant;
    end
    addr_err_d   = addr_err_q | (w_write & w_oob);
    rd_pend_d    = w_scan;
    vblank_d     = (vga_row_i >= c_VBLANK_ROW);
    frame_cnt_d  = frame_cnt_q;
    if (vblank_d && !vblank_q) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= 1'b0;
      rd_pend_q    <= 1'b0;
      vblank_q     <= 1'b1;
      frame_cnt_q  <= 16'd0;
      addr_err_q   <= 1'b0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      rd_pend_q    <= rd_pend_d;
      vblank_q     <= vblank_d;
      frame_cnt_q  <= frame_cnt_d;
      addr_err_q   <= addr_err_d;
      addr_hold_q  <= addr_hold_d;
      wdata_hold_q <= wdata_hold_d;
    end
  end

  // Read data lands one cycle after the scan address; blank it otherwise.
  assign vga_din_o   = rd_pend_q ? ram_rdata_i : 12'h000;
  assign vblank_o    = vblank_q;
  assign frame_cnt_o = frame_cnt_q;
  assign addr_err_o  = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vram_port_arbiter
//  Description : Scoreboard bench for vram_port_arbiter with a cycle-level
//                reference model of the port-sharing rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_port_arbiter;

  localparam int FB_W   = 320;
  localparam int FB_H   = 240;
  localparam int AW     = 17;
  localparam int PIXELS = FB_W * FB_H;

  logic          clk;
  logic          rst_n;
  logic [9:0]    vga_row;
  logic [9:0]    vga_col;
  logic          vga_rdn;
  logic [11:0]   vga_din;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [11:0]   ram_wdata;
  logic [11:0]   ram_rdata;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr,  req1_addr;
  logic [11:0]   req0_data,  req1_data;
  logic          req0_ready, req1_ready;
  logic          vblank;
  logic [15:0]   frame_cnt;
  logic          addr_err;

  vram_port_arbiter #(.FB_W(FB_W), .FB_H(FB_H), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vga_row_i    (vga_row),
    .vga_col_i    (vga_col),
    .vga_rdn_i    (vga_rdn),
    .vga_din_o    (vga_din),
    .ram_addr_o   (ram_addr),
    .ram_we_o     (ram_we),
    .ram_wdata_o  (ram_wdata),
    .ram_rdata_i  (ram_rdata),
    .req0_valid_i (req0_valid),
    .req0_addr_i  (req0_addr),
    .req0_data_i  (req0_data),
    .req0_ready_o (req0_ready),
    .req1_valid_i (req1_valid),
    .req1_addr_i  (req1_addr),
    .req1_data_i  (req1_data),
    .req1_ready_o (req1_ready),
    .vblank_o     (vblank),
    .frame_cnt_o  (frame_cnt),
    .addr_err_o   (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [11:0]   wdata;
    logic          chk_wdata;
    logic [1:0]    rdy;
    logic [11:0]   din;
    logic          vblank;
    logic [15:0]   frame;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state (what the arbiter has committed to so far)
  int            m_pref;       // writer that wins the next contention
  logic [AW-1:0] m_last_addr;  // address the port shows when idle
  bit            m_prev_scan;  // previous cycle issued a scan read
  bit            m_vblank;
  int            m_frames;
  bit            m_err;

  // Writer stimulus state
  bit            wv[2];
  logic [AW-1:0] wa[2];
  logic [11:0]   wd[2];
  logic [1:0]    last_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pref      = 0;
    m_last_addr = '0;
    m_prev_scan = 0;
    m_vblank    = 1;
    m_frames    = 0;
    m_err       = 0;
    last_rdy    = 2'b00;
  endtask

  task automatic apply_writers();
    req0_valid = wv[0]; req0_addr = wa[0]; req0_data = wd[0];
    req1_valid = wv[1]; req1_addr = wa[1]; req1_data = wd[1];
  endtask

  // Accepted writers move to a new pixel; unaccepted ones hold their request.
  task automatic refresh_writers(input logic [1:0] force_v, input logic [1:0] allow, input int oob_pct);
    for (int w = 0; w < 2; w++) begin
      if (!wv[w] || last_rdy[w]) begin
        wv[w] = allow[w] && (force_v[w] || ($urandom_range(0, 99) < 60));
        if ($urandom_range(0, 99) < oob_pct)
          wa[w] = AW'($urandom_range(PIXELS, (1 << AW) - 1));
        else
          wa[w] = AW'($urandom_range(0, PIXELS - 1));
        wd[w] = 12'($urandom);
      end
    end
  endtask

  // Hold reset for one cycle with both writers requesting.
  task automatic reset_cycle();
    exp_t e;
    @(posedge clk); #1;
    rst_n = 1'b0;
    wv[0] = 1; wv[1] = 1;
    apply_writers();
    vga_rdn = 1'b1; vga_row = 10'd100; vga_col = 10'd700;
    ram_rdata = 12'($urandom);
    e.addr = '0; e.we = 0; e.wdata = '0; e.chk_wdata = 1; e.rdy = 2'b00;
    e.din = '0; e.vblank = 1; e.frame = 16'd0; e.err = 0;
    sb.push_back(e);
    model_reset();
  endtask

  // Drive one cycle and predict the DUT response from the sharing rules.
  task automatic step(input logic rdn, input logic [9:0] row, input logic [9:0] col);
    exp_t e;
    int   win;
    bit   scan, anyv, both;
    int   lin;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    vga_rdn   = rdn;
    vga_row   = row;
    vga_col   = col;
    ram_rdata = 12'($urandom);
    apply_writers();
    scan = (rdn == 1'b0);
    anyv = wv[0] || wv[1];
    both = wv[0] && wv[1];
    win  = both ? m_pref : (wv[1] ? 1 : 0);
    e.we = 0; e.rdy = 2'b00; e.chk_wdata = 0; e.wdata = '0;
    if (scan) begin
      lin    = (int'(row) / 2) * FB_W + int'(col) / 2;
      e.addr = AW'(lin);
    end else if (anyv) begin
      e.addr      = wa[win];
      e.rdy[win]  = 1'b1;
      e.chk_wdata = 1;
      e.wdata     = wd[win];
      e.we        = (int'(wa[win]) < PIXELS);
    end else begin
      e.addr = m_last_addr;
    end
    e.din    = m_prev_scan ? ram_rdata : 12'h000;
    e.vblank = m_vblank;
    e.frame  = 16'(m_frames);
    e.err    = m_err;
    sb.push_back(e);
    // What the coming clock edge commits
    m_last_addr = e.addr;
    if (!scan && both) m_pref = 1 - win;
    if (!scan && anyv && !e.we) m_err = 1;
    m_prev_scan = scan;
    if (row >= 10'd480 && !m_vblank) m_frames = (m_frames + 1) % 65536;
    m_vblank = (row >= 10'd480);
    last_rdy = e.rdy;
  endtask

  // Compressed 525-row frame: a few active pixels then horizontal blank per row.
  task automatic run_frame(input logic [1:0] force_v, input logic [1:0] allow);
    for (int r = 0; r < 525; r++) begin
      for (int k = 0; k < 4; k++) begin
        refresh_writers(force_v, allow, 0);
        step((r < 480) ? 1'b0 : 1'b1, 10'(r), 10'($urandom_range(0, 639)));
      end
      for (int k = 0; k < 3; k++) begin
        refresh_writers(force_v, allow, 0);
        step(1'b1, 10'(r), 10'($urandom_range(640, 799)));
      end
    end
  endtask

  // Monitor: compare every presented cycle against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ram_addr",   32'(ram_addr),   32'(e.addr));
        chk("ram_we",     32'(ram_we),     32'(e.we));
        if (e.chk_wdata) chk("ram_wdata", 32'(ram_wdata), 32'(e.wdata));
        chk("req0_ready", 32'(req0_ready), 32'(e.rdy[0]));
        chk("req1_ready", 32'(req1_ready), 32'(e.rdy[1]));
        chk("vga_din",    32'(vga_din),    32'(e.din));
        chk("vblank",     32'(vblank),     32'(e.vblank));
        chk("frame_cnt",  32'(frame_cnt),  32'(e.frame));
        chk("addr_err",   32'(addr_err),   32'(e.err));
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    vga_rdn = 1'b1; vga_row = '0; vga_col = '0; ram_rdata = '0;
    for (int w = 0; w < 2; w++) begin wv[w] = 0; wa[w] = '0; wd[w] = '0; end
    apply_writers();
    model_reset();

    // Reset held with both writers requesting
    repeat (3) reset_cycle();

    // Release into contention: grants 0,1,0,1 with the loser holding
    wv[0] = 1; wa[0] = AW'(17'd1000); wd[0] = 12'hA0A;
    wv[1] = 1; wa[1] = AW'(17'd2000); wd[1] = 12'h5B5;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 10'd100, 10'd700);
      refresh_writers(2'b11, 2'b11, 0);
    end

    // Scan priority: row 2, col 4 -> pixel 322, writer 0 waits
    wv[0] = 1; wv[1] = 0;
    step(1'b0, 10'd2, 10'd4);
    step(1'b1, 10'd2, 10'd650);   // read data from the scan above shows here
    refresh_writers(2'b00, 2'b11, 0);

    // Three frames: first with only writer 1 always requesting, then mixed
    run_frame(2'b10, 2'b10);
    run_frame(2'b00, 2'b11);
    run_frame(2'b00, 2'b11);
    @(negedge clk);
    chk("frame_cnt_after_3_frames", 32'(frame_cnt), 32'd3);

    // Out-of-range write is accepted but never reaches the RAM
    wv[0] = 1; wa[0] = AW'(PIXELS); wd[0] = 12'hFFF;
    wv[1] = 0;
    step(1'b1, 10'd100, 10'd700);
    for (int k = 0; k < 200; k++) begin
      refresh_writers(2'b00, 2'b11, 10);
      step(($urandom_range(0, 1) == 0) ? 1'b0 : 1'b1, 10'($urandom_range(0, 479)), 10'($urandom_range(0, 799)));
    end
    // Far end of the row range stays in vblank
    refresh_writers(2'b00, 2'b11, 0);
    step(1'b1, 10'd1023, 10'd700);
    refresh_writers(2'b00, 2'b11, 0);
    step(1'b1, 10'd600, 10'd10);

    // Asynchronous reset mid-frame, between clock edges
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_frame_cnt",  32'(frame_cnt),  32'd0);
    chk("async_vblank",     32'(vblank),     32'd1);
    chk("async_addr_err",   32'(addr_err),   32'd0);
    chk("async_ram_we",     32'(ram_we),     32'd0);
    chk("async_req0_ready", 32'(req0_ready), 32'd0);
    chk("async_ram_addr",   32'(ram_addr),   32'd0);
    chk("async_vga_din",    32'(vga_din),    32'd0);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Owns the single port of the 320x240x12-bit frame VRAM and shares it between VGA scan-out and two game-side pixel writers (background clear engine, sprite drawer).
- Scan-out has absolute priority while the VGA timing block requests pixels.
- Writers are served round-robin only in cycles where scan-out does not need the port.
- Also provides frame-sync outputs so game logic can align drawing to vertical blanking.

Parameters:
- FB_W, 320, framebuffer width in pixels (each pixel is shown as 2x2 screen pixels).
- FB_H, 240, framebuffer height in pixels.
- AW, 17, VRAM address width; must satisfy 2^AW >= FB_W*FB_H.

Ports:
- clk  in  1  pixel clock (25 MHz), shared with VGA timing block
- rst_n  in  1  asynchronous active-low reset
- vga_row  in  10  screen row from VGA timing (registered there)
- vga_col  in  10  screen column from VGA timing
- vga_rdn  in  1  0 = VGA reading this cycle
- vga_din  out  12  pixel data to VGA Din ({B,G,R} 4 bits each)
- ram_addr  out  AW  VRAM address
- ram_we  out  1  VRAM write enable
- ram_wdata  out  12  VRAM write data
- ram_rdata  in  12  VRAM synchronous read data (1-cycle latency)
- req0_valid / req1_valid  in  1  writer n has a pixel to write
- req0_addr / req1_addr  in  AW  linear pixel address (y*FB_W+x)
- req0_data / req1_data  in  12  pixel value
- req0_ready / req1_ready  out  1  writer n is accepted this cycle
- vblank  out  1  high while vga_row >= 480 (unsigned)
- frame_cnt  out  16  count of completed frames
- addr_err  out  1  sticky: an out-of-range write was accepted

Behaviour:
- Reset (async, rst_n=0): ram_we=0, ram_addr=0, ram_wdata=0, vga_din=0, req*_ready=0, vblank=1, frame_cnt=0, addr_err=0, rr_ptr=0, rd_pend=0.
- Reset is mid-frame safe: on release the block resumes using whatever row/col values are current. No partial write is issued.
- Per-cycle mode, decided combinationally from vga_rdn and the valids:
  - SCAN (vga_rdn=0): ram_we=0; ram_addr = vga_row[9:1]*FB_W + vga_col[9:1]; both readies 0. Implement the multiply as (r<<8)+(r<<6) for the default.
  - WRITE (vga_rdn=1 and any valid): grant one writer; ram_we=1; ram_addr/ram_wdata from the granted writer; granted ready=1, the other 0.
  - IDLE (vga_rdn=1, no valid): ram_we=0, ram_addr held, readies 0.
- Arbitration:
  - Only one writer valid: that writer wins.
  - Both valid: the writer selected by rr_ptr wins, then rr_ptr <= index of the loser.
  - rr_ptr does not change in SCAN or IDLE.
- Handshake:
  - Transfer occurs when valid & ready in the same cycle.
  - Writers hold addr/data/valid stable until ready.
  - ready never asserts in SCAN; ready is combinational.
- Out-of-range write (addr >= FB_W*FB_H):
  - Accepted (ready=1), ram_we forced 0, addr_err set.
  - addr_err clears only on reset.
- Read return:
  - rd_pend <= ~vga_rdn (registered).
  - vga_din = rd_pend ? ram_rdata : 12'h000, so data arrives 1 cycle after the address.
  - This one-pixel lag is constant and accepted for the design.
- Frame sync:
  - vblank registered: vblank <= (vga_row >= 480).
  - frame_cnt increments by 1 on the 0->1 edge of vblank and wraps 0xFFFF->0.
- Writes in the same cycle as a SCAN transition: mode follows the current vga_rdn only. No lookahead; a write in the last blank cycle is allowed.

Test Plan:
- Reset: hold rst_n=0 with valids high -> all outputs at reset values, no ram_we. Release -> first grant goes to req0 (rr_ptr=0).
- Scan priority: vga_rdn=0, row=2, col=4, req0_valid=1 -> ram_addr=322, ram_we=0, req0_ready=0. Next cycle vga_din equals ram_rdata.
- Round-robin: vga_rdn=1, both valid for 4 cycles -> grants 0,1,0,1; ram_wdata alternates req0_data/req1_data.
- Blank-only writes: full 800x525 frame with req1 continuously valid -> writes occur only when vga_rdn=1, none during 640x480 active; vga_din=0 whenever rd_pend=0.
- Out-of-range: req0_addr=76800, vga_rdn=1 -> req0_ready=1, ram_we=0, addr_err=1 and stays 1 until reset.
- Frame counter: run 3 frames from reset -> frame_cnt=3; vblank high for rows 480..1023 of the row sequence. Async reset mid-frame -> frame_cnt=0 immediately, with no clock edge required.
